// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the single-outstanding imem handshake,
// and loads the IF/ID register feeding decode (stalls, redirects, bubbles).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_enable,
  input  logic        if_id_enable,
  input  logic        mux_sel_IF,
  input  logic [31:0] pc_branch_value,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        fetch_valid
);

  // state  | meaning
  // IDLE   | out of reset, request starts next cycle
  // REQ    | imem_req high at pc_reg, waiting for grant
  // WAIT   | granted, waiting for rvalid (dropped if discard set)
  // HOLD   | response captured while stalled, waiting for enables
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] pc_reg;
  logic [31:0] fetch_pc;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        discard;

  logic        redirect;
  logic        advance;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] deliver_pc;
  logic [31:0] branch_target;

  always_comb begin
    redirect      = mux_sel_IF & if_id_enable;
    advance       = pc_enable & if_id_enable;
    branch_target = pc_branch_value & 32'hFFFF_FFFC;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    deliver_pc    = fetch_pc;
    if (!redirect) begin
      case (state)
        S_WAIT: deliver = imem_rvalid & ~discard & advance;
        S_HOLD: begin
          deliver       = advance;
          deliver_instr = hold_instr;
          deliver_pc    = hold_pc;
        end
        default: deliver = 1'b0;
      endcase
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pc_reg     <= RESET_PC;
      fetch_pc   <= 32'h0;
      hold_instr <= 32'h0;
      hold_pc    <= 32'h0;
      discard    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (redirect) pc_reg <= branch_target;
          if (imem_gnt) begin
            fetch_pc <= pc_reg;
            state    <= S_WAIT;
            // granted on the old address while redirecting: its data is stale
            discard  <= redirect;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc_reg <= branch_target;
            if (imem_rvalid) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else begin
              discard <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= S_REQ;
            end else if (advance) begin
              pc_reg <= fetch_pc + 32'd4;
              state  <= S_REQ;
            end else begin
              hold_instr <= imem_rdata;
              hold_pc    <= fetch_pc;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc_reg <= branch_target;
            state  <= S_REQ;
          end else if (advance) begin
            pc_reg <= hold_pc + 32'd4;
            state  <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instruction <= NOP_INSTR;
      pc          <= 32'h0;
      fetch_valid <= 1'b0;
    end else if (redirect) begin
      instruction <= NOP_INSTR;
      fetch_valid <= 1'b0;
    end else if (deliver) begin
      instruction <= deliver_instr;
      pc          <= deliver_pc;
      fetch_valid <= 1'b1;
    end else if (if_id_enable) begin
      instruction <= NOP_INSTR;
      fetch_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small imem responder with programmable
// response latency plus per-scenario tasks with hand-computed expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clock;
  logic        reset;
  logic        pc_enable;
  logic        if_id_enable;
  logic        mux_sel_IF;
  logic [31:0] pc_branch_value;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        fetch_valid;

  int          passed;
  int          total;
  int          rsp_lat;
  int          pend_cnt;
  logic [31:0] pend_addr;

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clock(clock), .reset(reset), .pc_enable(pc_enable), .if_id_enable(if_id_enable),
    .mux_sel_IF(mux_sel_IF), .pc_branch_value(pc_branch_value),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .fetch_valid(fetch_valid)
  );

  always #5 clock = ~clock;

  // Advance one clock; the responder answers rsp_lat cycles after a grant.
  task automatic step();
    logic        g;
    logic [31:0] a;
    @(negedge clock);
    g = imem_req & imem_gnt;
    a = imem_addr;
    @(posedge clock);
    #1;
    if (pend_cnt > 0) pend_cnt--;
    if (g) begin
      pend_cnt  = rsp_lat;
      pend_addr = a;
    end
    imem_rvalid = (pend_cnt == 1);
    imem_rdata  = imem_rvalid ? (pend_addr ^ KEY) : 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", imem_req); else passed++;
    total++; if (instruction !== NOP) $display("FAIL rst_instr got=%h exp=%h", instruction, NOP); else passed++;
    total++; if (pc !== 32'h0) $display("FAIL rst_pc got=%h exp=0", pc); else passed++;
    total++; if (fetch_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", fetch_valid); else passed++;
    reset = 1'b1;
  endtask

  task automatic test_seq_fetch();
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL seq_req0 got=%b/%h exp=1/0", imem_req, imem_addr); else passed++;
    step();
    total++; if (imem_req !== 1'b0) $display("FAIL seq_wait_req got=%b exp=0", imem_req); else passed++;
    step();
    total++; if (instruction !== 32'hA5A5_0000 || pc !== 32'h0 || fetch_valid !== 1'b1)
      $display("FAIL seq_if0 got=%h/%h/%b exp=a5a50000/0/1", instruction, pc, fetch_valid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL seq_req4 got=%b/%h exp=1/4", imem_req, imem_addr); else passed++;
    step();
    total++; if (instruction !== NOP || pc !== 32'h0 || fetch_valid !== 1'b0)
      $display("FAIL seq_bubble got=%h/%h/%b exp=%h/0/0", instruction, pc, fetch_valid, NOP); else passed++;
    step();
    total++; if (instruction !== 32'hA5A5_0004 || pc !== 32'h4 || fetch_valid !== 1'b1)
      $display("FAIL seq_if4 got=%h/%h/%b exp=a5a50004/4/1", instruction, pc, fetch_valid); else passed++;
    step();
    total++; if (fetch_valid !== 1'b0) $display("FAIL seq_bubble2 got=%b exp=0", fetch_valid); else passed++;
  endtask

  task automatic test_hold_stall();
    pc_enable    = 1'b0;
    if_id_enable = 1'b0;
    step();
    total++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || pc !== 32'h4 || instruction !== NOP)
      $display("FAIL hold_c1 got=%b/%b/%h/%h exp=0/0/4/%h", imem_req, fetch_valid, pc, instruction, NOP); else passed++;
    step();
    total++; if (imem_req !== 1'b0 || pc !== 32'h4) $display("FAIL hold_c2 got=%b/%h exp=0/4", imem_req, pc); else passed++;
    step();
    total++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) $display("FAIL hold_c3 got=%b/%b exp=0/0", imem_req, fetch_valid); else passed++;
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    step();
    total++; if (instruction !== 32'hA5A5_0008 || pc !== 32'h8 || fetch_valid !== 1'b1)
      $display("FAIL hold_release got=%h/%h/%b exp=a5a50008/8/1", instruction, pc, fetch_valid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) $display("FAIL hold_next got=%b/%h exp=1/c", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_branch_wait();
    rsp_lat = 2;
    step();
    total++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) $display("FAIL bw_wait got=%b/%b exp=0/0", imem_req, fetch_valid); else passed++;
    mux_sel_IF      = 1'b1;
    pc_branch_value = 32'h40;
    step();
    mux_sel_IF = 1'b0;
    total++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0) $display("FAIL bw_redirect got=%b/%b exp=0/0", imem_req, fetch_valid); else passed++;
    step();
    total++; if (fetch_valid !== 1'b0 || instruction !== NOP || pc !== 32'h8)
      $display("FAIL bw_discard got=%b/%h/%h exp=0/%h/8", fetch_valid, instruction, pc, NOP); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL bw_target got=%b/%h exp=1/40", imem_req, imem_addr); else passed++;
    rsp_lat = 1;
    step();
    step();
    total++; if (instruction !== 32'hA5A5_0040 || pc !== 32'h40 || fetch_valid !== 1'b1)
      $display("FAIL bw_if40 got=%h/%h/%b exp=a5a50040/40/1", instruction, pc, fetch_valid); else passed++;
  endtask

  task automatic test_branch_stall();
    imem_gnt        = 1'b0;
    mux_sel_IF      = 1'b1;
    pc_branch_value = 32'h200;
    if_id_enable    = 1'b0;
    step();
    total++; if (imem_addr !== 32'h44 || fetch_valid !== 1'b1) $display("FAIL bs_c1 got=%h/%b exp=44/1", imem_addr, fetch_valid); else passed++;
    step();
    total++; if (imem_addr !== 32'h44 || instruction !== 32'hA5A5_0040)
      $display("FAIL bs_c2 got=%h/%h exp=44/a5a50040", imem_addr, instruction); else passed++;
    if_id_enable = 1'b1;
    step();
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL bs_redirect got=%b/%h exp=1/200", imem_req, imem_addr); else passed++;
    total++; if (fetch_valid !== 1'b0 || instruction !== NOP || pc !== 32'h40)
      $display("FAIL bs_flush got=%b/%h/%h exp=0/%h/40", fetch_valid, instruction, pc, NOP); else passed++;
  endtask

  task automatic test_misaligned_wrap();
    pc_branch_value = 32'h103;
    step();
    total++; if (imem_addr !== 32'h100) $display("FAIL misaligned got=%h exp=100", imem_addr); else passed++;
    pc_branch_value = 32'hFFFF_FFFC;
    step();
    total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL top_addr got=%h exp=fffffffc", imem_addr); else passed++;
    mux_sel_IF = 1'b0;
    imem_gnt   = 1'b1;
    step();
    step();
    total++; if (instruction !== 32'h5A5A_FFFC || pc !== 32'hFFFF_FFFC || fetch_valid !== 1'b1)
      $display("FAIL wrap_if got=%h/%h/%b exp=5a5afffc/fffffffc/1", instruction, pc, fetch_valid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_addr got=%b/%h exp=1/0", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_async_reset();
    step();
    #1 reset = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || fetch_valid !== 1'b0 || instruction !== NOP || pc !== 32'h0)
      $display("FAIL arst_now got=%b/%b/%h/%h exp=0/0/%h/0", imem_req, fetch_valid, instruction, pc, NOP); else passed++;
    #1 reset = 1'b1;
    step();
    total++; if (fetch_valid !== 1'b0 || instruction !== NOP) $display("FAIL arst_late_rvalid got=%b/%h exp=0/%h", fetch_valid, instruction, NOP); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL arst_restart got=%b/%h exp=1/0", imem_req, imem_addr); else passed++;
    step();
    step();
    total++; if (instruction !== 32'hA5A5_0000 || pc !== 32'h0 || fetch_valid !== 1'b1 || imem_addr !== 32'h4)
      $display("FAIL arst_fetch got=%h/%h/%b/%h exp=a5a50000/0/1/4", instruction, pc, fetch_valid, imem_addr); else passed++;
  endtask

  initial begin
    clock           = 1'b0;
    reset           = 1'b0;
    pc_enable       = 1'b1;
    if_id_enable    = 1'b1;
    mux_sel_IF      = 1'b0;
    pc_branch_value = 32'h0;
    imem_gnt        = 1'b1;
    imem_rvalid     = 1'b0;
    imem_rdata      = 32'h0;
    rsp_lat         = 1;
    pend_cnt        = 0;
    pend_addr       = 32'h0;
    passed          = 0;
    total           = 0;
    test_reset();
    test_seq_fetch();
    test_hold_stall();
    test_branch_wait();
    test_branch_stall();
    test_misaligned_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch (IF) stage. It sits directly upstream of the decode stage and feeds it through the IF/ID pipeline register.
- Owns the PC register and the instruction-memory request/response handshake.
- Applies PC-enable and IF/ID-enable stalls from the hazard unit.
- Applies branch redirects (taken flag plus target) produced combinationally by decode.
- Presents `instruction` and `pc` of the fetched word to decode.

Parameters:
RESET_PC, 32'h00000000, PC value fetched first after reset
NOP_INSTR, 32'h00000013, bubble word loaded into IF/ID on flush/empty (addi x0,x0,0)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
pc_enable  input  1  1 = PC may advance (hazard unit)
if_id_enable  input  1  1 = IF/ID register may load (hazard unit)
mux_sel_IF  input  1  branch taken in decode; redirect PC
pc_branch_value  input  32  branch target from decode
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (word aligned)
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction word
instruction  output  32  IF/ID instruction to decode
pc  output  32  IF/ID address of `instruction`
fetch_valid  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, reset=0):
  - pc_reg=RESET_PC, state=IDLE, discard=0, hold buffer cleared.
  - instruction=NOP_INSTR, pc=0, fetch_valid=0, imem_req=0.
- FSM states: IDLE, REQ, WAIT, HOLD. At most one outstanding request.
- IDLE: imem_req=0. Goes to REQ on the first clock after reset deasserts.
- REQ:
  - Outputs: imem_req=1, imem_addr=pc_reg.
  - imem_gnt=1 -> latch fetch_pc=pc_reg, go to WAIT.
  - imem_gnt=0 -> stay in REQ; the address may change (redirect) while not granted.
- WAIT: imem_req=0. On imem_rvalid=1:
  - discard=1 -> drop data, clear discard, go to REQ.
  - Else, if pc_enable=1 and if_id_enable=1:
    - IF/ID <= {imem_rdata, fetch_pc, valid=1}.
    - pc_reg <= fetch_pc+4.
    - Go to REQ.
  - Else -> store {imem_rdata, fetch_pc} in the hold buffer, go to HOLD.
- HOLD: imem_req=0. When pc_enable=1 and if_id_enable=1:
  - IF/ID <= hold buffer, valid=1.
  - pc_reg <= held pc+4.
  - Go to REQ.
- IF/ID when no instruction is delivered this cycle:
  - if_id_enable=1 -> IF/ID loads {NOP_INSTR, pc unchanged, valid=0}.
  - if_id_enable=0 -> IF/ID holds all fields.
- Redirect: mux_sel_IF=1 and if_id_enable=1. Highest priority, overrides the delivery and stall rules above.
  - pc_reg <= {pc_branch_value[31:2], 2'b00}.
  - IF/ID flushed: instruction=NOP_INSTR, fetch_valid=0, pc unchanged.
  - From WAIT without rvalid -> set discard=1, stay in WAIT.
  - From WAIT with rvalid -> drop data, go to REQ.
  - From HOLD -> drop the held word, go to REQ.
  - From REQ with imem_gnt=1 in the same cycle -> go to WAIT with discard=1.
  - From REQ without grant -> stay in REQ; the new address is driven next cycle.
- mux_sel_IF=1 with if_id_enable=0: the branch is stalled in decode; no redirect. Decode re-evaluates the branch next cycle.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
- Latency: 1 cycle grant plus 1 cycle response gives a minimum of 2 cycles per instruction.
  - The first IF/ID load occurs no earlier than cycle 3 after reset release.

Test Plan:
- Reset/sequential fetch:
  - Stimulus: RESET_PC=0; imem grants immediately; rvalid the cycle after grant with rdata=addr^32'hA5A5_0000; enables=1.
  - Response: IF/ID shows pc=0,4,8 with matching words, fetch_valid pulses 1 every 2 cycles, NOP_INSTR/valid=0 in between.
- Stall in HOLD:
  - Stimulus: pc_enable=if_id_enable=0 when the response for pc=8 arrives, held for 3 cycles.
  - Response: IF/ID frozen, no imem_req. On release, IF/ID shows pc=8 with its word; next request address is 12.
- Branch with outstanding request:
  - Stimulus: mux_sel_IF=1, pc_branch_value=32'h40 while in WAIT for pc=12.
  - Response: IF/ID flushed (valid=0); the pc=12 response is discarded; next imem_addr=32'h40.
- Branch during stall:
  - Stimulus: mux_sel_IF=1 with if_id_enable=0 for 2 cycles, then if_id_enable=1.
  - Response: no redirect until the third cycle, then pc_reg=target.
- Misaligned target and wrap:
  - Stimulus A: pc_branch_value=32'h103.
  - Response A: imem_addr=32'h100.
  - Stimulus B: fetch at 32'hFFFFFFFC.
  - Response B: next imem_addr=0.
- Async reset mid-WAIT:
  - Stimulus: reset=0 between clock edges while a request is outstanding.
  - Response: outputs return to reset values immediately; after release fetch restarts at RESET_PC; the late rvalid is ignored in IDLE.
